// File: rtl/seqdivider.sv
// ---------------------------------------------------------------------------
// seqdivider
//   Multi-cycle 16-bit signed/unsigned integer divider. It uses restoring
//   shift-subtract and produces one quotient bit per cycle. Signed operands
//   are divided as magnitudes, and the signs are fixed up at the end. The
//   result truncates toward zero: the remainder takes the dividend's sign.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high; aborts any division
//   i_start      request a division (sampled only while idle)
//   i_is_signed  1 = two's-complement operands, 0 = unsigned (latched)
//   i_dividend   numerator (latched with i_start)
//   i_divisor    denominator (latched with i_start)
//   o_quotient   result, held until the next division writes it
//   o_remainder  result, held until the next division writes it
//   o_busy       high while iterating or fixing signs
//   o_done       one-cycle pulse when results are valid
//   o_div_zero   divisor was zero (quotient=FFFF, remainder=dividend)
//   o_ovfl       signed overflow, -32768 / -1 (quotient=8000, remainder=0)
// ---------------------------------------------------------------------------
module seqdivider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_signed,
  input  logic [15:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic [15:0] o_quotient,
  output logic [15:0] o_remainder,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero,
  output logic        o_ovfl
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation, kept at operand width
  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand. A negative value is negated only in signed
  // mode. |-32768| = 16'h8000 stays representable as unsigned.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v,
                                              input logic             sg);
    return (sg && v[DATA_W-1]) ? f_neg(v) : v;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_count;

  logic [DATA_W-1:0]   r_div;     // divisor magnitude
  logic [DATA_W-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   r_rem;     // partial remainder
  logic                r_qneg;    // quotient must be negated
  logic                r_rneg;    // remainder must be negated (dividend < 0)

  logic                w_accept;
  logic                w_in_div_zero;
  logic                w_in_ovfl;
  logic [DATA_W:0]     w_shift;
  logic signed [DATA_W+1:0] w_trial;
  logic                w_trial_neg;

  assign w_accept      = (r_state == S_IDLE) && i_start;
  assign w_in_div_zero = (i_divisor == '0);
  assign w_in_ovfl     = i_is_signed && (i_dividend == 16'h8000) &&
                         (i_divisor == 16'hFFFF);

  // The shifted partial remainder can reach 17 bits when the divisor is
  // large. The trial therefore gets one extra bit so that its sign is exact.
  assign w_shift     = {r_rem, r_quo[DATA_W-1]};
  assign w_trial     = $signed({1'b0, w_shift}) - $signed({2'b00, r_div});
  assign w_trial_neg = w_trial[DATA_W+1];

  // ---- control: state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (w_in_div_zero || w_in_ovfl) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (r_count == 5'd15) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        o_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control: iteration count and architected results ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
      o_ovfl      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count    <= '0;
            o_div_zero <= 1'b0;
            o_ovfl     <= 1'b0;
            // Exceptional cases finish right away. Their results are
            // written here, because they never pass through FIX.
            if (w_in_div_zero) begin
              o_quotient  <= 16'hFFFF;
              o_remainder <= i_dividend;
              o_div_zero  <= 1'b1;
            end else if (w_in_ovfl) begin
              o_quotient  <= 16'h8000;
              o_remainder <= '0;
              o_ovfl      <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_count <= r_count + 5'd1;
        end
        S_FIX: begin
          o_quotient  <= r_qneg ? f_neg(r_quo) : r_quo;
          o_remainder <= r_rneg ? f_neg(r_rem) : r_rem;
        end
        default: ;
      endcase
    end
  end

  // ---- datapath: operand capture and shift-subtract ----
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_div  <= f_mag(i_divisor, i_is_signed);
      r_quo  <= f_mag(i_dividend, i_is_signed);
      r_rem  <= '0;
      r_qneg <= i_is_signed && (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
      r_rneg <= i_is_signed && i_dividend[DATA_W-1];
    end else if (r_state == S_CALC) begin
      // If the trial is negative, the divisor did not fit and the shifted
      // remainder is kept. That value is known to fit in 16 bits.
      r_rem <= w_trial_neg ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
      r_quo <= {r_quo[DATA_W-2:0], ~w_trial_neg};
    end
  end

endmodule

// File: tb/tb_seqdivider.sv
module tb_seqdivider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        ovfl;

  int n_checks = 0;
  int n_errors = 0;

  seqdivider dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_is_signed (is_signed),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_busy      (busy),
    .o_done      (done),
    .o_div_zero  (div_zero),
    .o_ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic with truncating division, plus the
  // two exceptional cases.
  function automatic void model(input bit sg, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output bit dz, output bit ov, output int lat);
    int sa, sb, ua, ub;
    dz = 0; ov = 0; lat = 17;
    if (b == 16'h0000) begin
      q = 16'hFFFF; r = a; dz = 1; lat = 0;
    end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = 16'h0000; ov = 1; lat = 0;
    end else if (sg) begin
      sa = $signed(a); sb = $signed(b);
      q = 16'(sa / sb); r = 16'(sa % sb);
    end else begin
      ua = a; ub = b;
      q = 16'(ua / ub); r = 16'(ua % ub);
    end
  endfunction

  task automatic run_div(input string tag, input bit sg, input logic [15:0] a,
                         input logic [15:0] b, input bit hold_start);
    logic [15:0] q_e, r_e;
    bit dz_e, ov_e;
    int lat_e, lat, busy_cnt;
    model(sg, a, b, q_e, r_e, dz_e, ov_e, lat_e);
    @(negedge clk);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    // operands scrambled after the start edge must not matter
    dividend = 16'($urandom); divisor = 16'($urandom); is_signed = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, lat_e);
    check({tag, " busy_cycles"}, busy_cnt, (lat_e == 0) ? 0 : 17);
    check({tag, " quotient"}, quotient, q_e);
    check({tag, " remainder"}, remainder, r_e);
    check({tag, " divZero"}, div_zero, dz_e);
    check({tag, " ovfl"}, ovfl, ov_e);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, done, 1'b0);
    check({tag, " q_held"}, quotient, q_e);
  endtask

  initial begin
    logic [15:0] a, b;
    bit sg;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst quotient", quotient, 16'h0);
    check("rst remainder", remainder, 16'h0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst divZero", div_zero, 1'b0);
    check("rst ovfl", ovfl, 1'b0);
    rst = 1'b0;

    // directed cases
    run_div("u1000/7", 1'b0, 16'd1000, 16'd7, 1'b0);
    check("u1000/7 q142", quotient, 16'd142);
    run_div("s-7/2", 1'b1, 16'hFFF9, 16'd2, 1'b0);
    check("s-7/2 r", remainder, 16'hFFFF);
    run_div("s7/-2", 1'b1, 16'd7, 16'hFFFE, 1'b0);
    run_div("s-32768/-1", 1'b1, 16'h8000, 16'hFFFF, 1'b0);
    run_div("u8000/FFFF", 1'b0, 16'h8000, 16'hFFFF, 1'b0);
    run_div("s-32768/1", 1'b1, 16'h8000, 16'h0001, 1'b0);
    run_div("uFFFF/FFFF", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_div("uFFFE/FFFF", 1'b0, 16'hFFFE, 16'hFFFF, 1'b0);
    run_div("div0", 1'b0, 16'h1234, 16'h0000, 1'b0);
    run_div("hold", 1'b0, 16'd50000, 16'd123, 1'b1);
    run_div("hold_div0", 1'b1, 16'h8001, 16'h0000, 1'b1);

    // reset mid-calculation at iteration 8
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'h4321; divisor = 16'h0013;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst quotient", quotient, 16'h0);
    check("midrst remainder", remainder, 16'h0);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst divZero", div_zero, 1'b0);
    check("midrst ovfl", ovfl, 1'b0);
    rst = 1'b0;
    run_div("after_rst", 1'b0, 16'hFFFF, 16'h00FF, 1'b0);
    check("after_rst q257", quotient, 16'd257);

    // randomized operations, with the corner operands mixed in
    for (int i = 0; i < 200; i++) begin
      sg = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'h0000;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 15));
        3: a = 16'h8000;
        4: b = 16'hFFFF;
        default: ;
      endcase
      run_div("rand", sg, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
